// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: FSM encodings and direction constants.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/muxshift.sv
// Per-bit left/right select cell of the bidirectional shift datapath.
module muxshift (
  input  logic i_data1,
  input  logic i_data2,
  input  logic i_lr,
  output logic o_q
);
  import shift_pkg::*;

  assign o_q = (i_lr == DIR_LEFT) ? i_data1 : i_data2;

endmodule

// File: rtl/shift_seq_ctrl_next.sv
// Next-state vector of the shift register: one muxshift cell per bit,
// with the serial-in bit at each end chosen between fill and rotate wrap.
module shift_seq_ctrl_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_reg,
  input  logic             i_lr,
  input  logic             i_rotate,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_next
);

  logic w_in_left;
  logic w_in_right;

  assign w_in_left  = i_rotate ? i_reg[WIDTH-1] : i_fill;
  assign w_in_right = i_rotate ? i_reg[0]       : i_fill;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_left_src;
    logic w_right_src;

    if (i == 0) begin : g_lsb
      assign w_left_src = w_in_left;
    end else begin : g_lmid
      assign w_left_src = i_reg[i-1];
    end

    if (i == WIDTH-1) begin : g_msb
      assign w_right_src = w_in_right;
    end else begin : g_rmid
      assign w_right_src = i_reg[i+1];
    end

    muxshift u_cell (
      .i_data1 (w_left_src),
      .i_data2 (w_right_src),
      .i_lr    (i_lr),
      .o_q     (o_next[i])
    );
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: accepts a command, shifts one bit per clock for the commanded
// number of steps, then pulses done. Status outputs decode straight from state.
//
// state | meaning
// IDLE  | ready for a command; result of the previous command held on dout
// SHIFT | one shift per edge, counter decrements, last step at cnt == 1
// DONE  | one-cycle done pulse, final result on dout
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             lr,
  input  logic [AMT_W-1:0] amount,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_reg;
  logic [AMT_W-1:0]   r_cnt;
  logic               r_lr;
  logic               r_rotate;
  logic               r_fill;
  logic [WIDTH-1:0]   w_next;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && start_valid;

  shift_seq_ctrl_next #(.WIDTH(WIDTH)) u_next (
    .i_reg    (r_reg),
    .i_lr     (r_lr),
    .i_rotate (r_rotate),
    .i_fill   (r_fill),
    .o_next   (w_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_valid) w_state_nxt = (amount == '0) ? DONE : SHIFT;
      SHIFT:   if (r_cnt == AMT_W'(1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= '0;
      r_cnt    <= '0;
      r_lr     <= DIR_RIGHT;
      r_rotate <= 1'b0;
      r_fill   <= 1'b0;
    end else if (w_accept) begin
      r_reg    <= din;
      r_cnt    <= amount;
      r_lr     <= lr;
      r_rotate <= rotate;
      r_fill   <= fill;
    end else if (r_state == SHIFT) begin
      r_reg <= w_next;
      // Guarded so the counter can never wrap even if SHIFT were entered with zero.
      if (r_cnt != '0) r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  assign dout        = r_reg;
  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state == SHIFT) || (r_state == DONE);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed plan cases, randomized
// commands against an arithmetic reference, reset abort and back-to-back flow.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] din;
  logic             lr;
  logic [AMT_W-1:0] amount;
  logic             rotate;
  logic             fill;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .din         (din),
    .lr          (lr),
    .amount      (amount),
    .rotate      (rotate),
    .fill        (fill),
    .dout        (dout),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of the whole command computed in one step from the shift rules.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic l,
                                             input int k, input logic rot, input logic f);
    logic [WIDTH-1:0] ones;
    int               m;
    ones = '1;
    if (rot) begin
      m = k % WIDTH;
      if (m == 0) return d;
      return l ? ((d << m) | (d >> (WIDTH - m))) : ((d >> m) | (d << (WIDTH - m)));
    end
    if (k >= WIDTH) return f ? ones : '0;
    if (l) return (d << k) | (f ? ~(ones << k) : '0);
    return (d >> k) | (f ? ~(ones >> k) : '0);
  endfunction

  task automatic run_cmd(input string name, input logic [WIDTH-1:0] d, input logic l,
                         input logic [AMT_W-1:0] k, input logic rot, input logic f,
                         input bit scramble);
    logic [WIDTH-1:0] exp;
    int               done_cyc;
    exp = model(d, l, int'(k), rot, f);
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before: got %b want 1", name, start_ready);
    end
    start_valid = 1'b1; din = d; lr = l; amount = k; rotate = rot; fill = f;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_accept: got busy=%b ready=%b want 1/0", name, busy, start_ready);
    end
    done_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (scramble) begin
        din = WIDTH'($urandom); lr = 1'($urandom); fill = 1'($urandom);
        rotate = 1'($urandom); amount = AMT_W'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (done_cyc != int'(k) + 1) begin
      failures++;
      $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, int'(k) + 1);
    end
    checks++;
    if (dout !== exp) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, dout, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || dout !== exp) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b ready=%b dout=%h want 0/0/1/%h",
               name, done, busy, start_ready, dout, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_valid = 1'b0; din = '0; lr = 1'b0; amount = '0; rotate = 1'b0; fill = 1'b0;
    #2;
    checks++;
    if (dout !== '0 || busy !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got dout=%h busy=%b done=%b ready=%b want 00/0/0/1",
               dout, busy, done, start_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    @(negedge clk);
    start_valid = 1'b1; din = 8'hFF; lr = 1'b1; amount = 3'd5; rotate = 1'b0; fill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_shift: got dout=%h busy=%b done=%b ready=%b want 00/0/0/1",
               dout, busy, done, start_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
    end
  endtask

  task automatic test_directed;
    run_cmd("fill_left3",  8'b1001_0110, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    run_cmd("rot_right1",  8'hA5,        1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    run_cmd("amount_zero", 8'h3C,        1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    run_cmd("fill1_right7",8'h00,        1'b0, 3'd7, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      run_cmd("random", WIDTH'($urandom), 1'($urandom), AMT_W'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    localparam int K1 = 2;
    localparam int K2 = 3;
    logic [WIDTH-1:0] exp1, exp2;
    int done1, done2, dones;
    exp1 = model(8'h81, 1'b1, K1, 1'b1, 1'b0);
    exp2 = model(8'h0F, 1'b0, K2, 1'b0, 1'b1);
    done1 = K1 + 1;
    done2 = K1 + 2 + K2 + 1;
    dones = 0;
    @(negedge clk);
    start_valid = 1'b1; din = 8'h81; lr = 1'b1; amount = 3'(K1); rotate = 1'b1; fill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    din = 8'h0F; lr = 1'b0; amount = 3'(K2); rotate = 1'b0; fill = 1'b1;
    for (int c = 1; c <= done2 + 2; c++) begin
      logic exp_ready;
      logic exp_done;
      exp_ready = (c == done1 + 1) || (c > done2);
      exp_done  = (c == done1) || (c == done2);
      if (c == done1 + 2) start_valid = 1'b0;
      checks++;
      if (start_ready !== exp_ready || done !== exp_done) begin
        failures++;
        $display("FAIL b2b_cycle%0d: got ready=%b done=%b want %b/%b",
                 c, start_ready, done, exp_ready, exp_done);
      end
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (dout !== ((c == done1) ? exp1 : exp2)) begin
          failures++;
          $display("FAIL b2b_result%0d: got %h want %h", c, dout, (c == done1) ? exp1 : exp2);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d want 2", dones);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
